// File: rtl/i2s_mono_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_mono_rx_pkg
//  Description : Shared constants and types for the slave-mode I2S mono
//                receiver: frame state encoding, slot polarity, and
//                bit-counter geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2s_mono_rx_pkg;

  // Frame-alignment state encoding
  localparam logic [1:0] ST_SYNC_WAIT = 2'd0;
  localparam logic [1:0] ST_LEFT      = 2'd1;
  localparam logic [1:0] ST_RIGHT     = 2'd2;

  typedef enum logic [1:0] {
    SYNC_WAIT = ST_SYNC_WAIT,
    LEFT      = ST_LEFT,
    RIGHT     = ST_RIGHT
  } state_e;

  // LRCLK level that marks the left slot
  localparam logic LEFT_LEVEL = 1'b0;

  // Per-slot bit counter: 6 bits, saturating at 63
  localparam int CNT_W   = 6;
  localparam int CNT_MAX = 63;

endpackage : i2s_mono_rx_pkg
`default_nettype wire

// File: rtl/i2s_mono_rx_sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Single-bit two-flop synchroniser for bringing an
//                asynchronous level into the clk domain. No reset: the
//                flops settle to the input level within two cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
  input  logic clk,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back capture stages to resolve metastability
  always_ff @(posedge clk) begin
    meta_q <= d_i;
    sync_q <= meta_q;
  end

  assign q_o = sync_q;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/i2s_mono_rx.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_mono_rx
//  Description : Slave-mode I2S receiver. Captures WIDTH bits MSB-first from
//                each channel slot, checks slot length, downmixes left and
//                right to a mono sample and emits it with a one-cycle strobe
//                per frame. Malformed slots raise a one-cycle frame_err.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_mono_rx #(
  parameter int WIDTH     = 16,
  parameter int SLOT_BITS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i2s_sclk,
  input  logic             i2s_lrclk,
  input  logic             i2s_sdata,
  output logic [WIDTH-1:0] data_out,
  output logic             stb_out,
  output logic             frame_err
);

  import i2s_mono_rx_pkg::*;

  // Counter thresholds, expressed in counter width
  localparam logic [CNT_W-1:0] C_IDX_FIRST = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_IDX_LAST  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] C_SLOT_MIN  = CNT_W'(WIDTH + 1);
  localparam logic [CNT_W-1:0] C_SLOT_MAX  = CNT_W'((SLOT_BITS > CNT_MAX) ? CNT_MAX : SLOT_BITS);
  localparam logic [CNT_W-1:0] C_CNT_SAT   = CNT_W'(CNT_MAX);

  // --------------------------------------------------------------------------
  // Input synchronisation and edge detection
  // --------------------------------------------------------------------------
  logic w_sclk_s;
  logic w_lrclk_s;
  logic w_sdata_s;

  sync_2ff u_sync_sclk  (.clk(clk), .d_i(i2s_sclk),  .q_o(w_sclk_s));
  sync_2ff u_sync_lrclk (.clk(clk), .d_i(i2s_lrclk), .q_o(w_lrclk_s));
  sync_2ff u_sync_sdata (.clk(clk), .d_i(i2s_sdata), .q_o(w_sdata_s));

  logic sclk_hist_q;
  logic lrclk_hist_q;

  // History of the synchronised clocks; tracks the line level, so no reset
  always_ff @(posedge clk) begin
    sclk_hist_q  <= w_sclk_s;
    lrclk_hist_q <= w_lrclk_s;
  end

  logic w_sclk_rise;
  logic w_lr_to_left;
  logic w_lr_to_right;
  logic w_lr_edge;

  assign w_sclk_rise   = w_sclk_s & ~sclk_hist_q;
  assign w_lr_to_left  = (w_lrclk_s == LEFT_LEVEL) && (lrclk_hist_q != LEFT_LEVEL);
  assign w_lr_to_right = (w_lrclk_s != LEFT_LEVEL) && (lrclk_hist_q == LEFT_LEVEL);
  assign w_lr_edge     = w_lr_to_left | w_lr_to_right;

  // --------------------------------------------------------------------------
  // Bit counter and shift register
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;

  // Next-state: an LRCLK edge opens a new slot before any coincident SCLK
  // rise is considered, so that rise lands on index 0 (the delay bit)
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (w_lr_edge) begin
      cnt_d = w_sclk_rise ? C_IDX_FIRST : '0;
    end else if (w_sclk_rise) begin
      if ((cnt_q >= C_IDX_FIRST) && (cnt_q <= C_IDX_LAST)) begin
        shift_d = {shift_q[WIDTH-2:0], w_sdata_s};
      end
      if (cnt_q != C_CNT_SAT) begin
        cnt_d = cnt_q + C_IDX_FIRST;
      end
    end
  end

  // Counter and shift-register state
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  // --------------------------------------------------------------------------
  // Slot check and downmix
  // --------------------------------------------------------------------------
  logic             w_slot_ok;
  logic [WIDTH-1:0] left_q;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_mix;

  // cnt_q still holds the finished slot's length on the cycle its edge is seen
  assign w_slot_ok = (cnt_q >= C_SLOT_MIN) && (cnt_q <= C_SLOT_MAX);

  // Sign-extended sum; dropping the LSB is an arithmetic shift right by one,
  // which floors toward minus infinity and always fits back in WIDTH bits
  assign w_sum = {left_q[WIDTH-1], left_q} + {shift_q[WIDTH-1], shift_q};
  assign w_mix = w_sum[WIDTH:1];

  // --------------------------------------------------------------------------
  // Frame-alignment state machine
  // --------------------------------------------------------------------------
  state_e           state_q;
  logic [WIDTH-1:0] mix_q;
  logic             mix_vld_q;
  logic             err_pend_q;

  // Track left/right slots, validate each at its closing edge, and stage a
  // result (sample or error) for the output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SYNC_WAIT;
      left_q     <= '0;
      mix_q      <= '0;
      mix_vld_q  <= 1'b0;
      err_pend_q <= 1'b0;
    end else begin
      mix_vld_q  <= 1'b0;
      err_pend_q <= 1'b0;
      case (state_q)
        SYNC_WAIT: begin
          if (w_lr_to_left) begin
            state_q <= LEFT;
          end
        end
        LEFT: begin
          if (w_lr_to_right) begin
            if (w_slot_ok) begin
              left_q  <= shift_q;
              state_q <= RIGHT;
            end else begin
              err_pend_q <= 1'b1;
              state_q    <= SYNC_WAIT;
            end
          end
        end
        RIGHT: begin
          if (w_lr_to_left) begin
            if (w_slot_ok) begin
              mix_q     <= w_mix;
              mix_vld_q <= 1'b1;
            end else begin
              err_pend_q <= 1'b1;
            end
            state_q <= LEFT;
          end
        end
        default: begin
          state_q <= SYNC_WAIT;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output register
  // --------------------------------------------------------------------------

  // Publish sample and strobe together; sample holds until the next good frame
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out  <= '0;
      stb_out   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      stb_out   <= mix_vld_q;
      frame_err <= err_pend_q;
      if (mix_vld_q) begin
        data_out <= mix_q;
      end
    end
  end

endmodule : i2s_mono_rx
`default_nettype wire
